// File: rtl/wash_phase_timer_pkg.sv
// Shared definitions for the washing-machine timer front end and control FSM.
// Phase encoding, default tick constants and FSM state names live here so that
// both blocks use the same encodings.
package wash_pkg;

    // Operating phase decoded from the FSM's actuator commands.
    typedef enum logic [2:0] {
        P_IDLE  = 3'd0,
        P_FILL  = 3'd1,
        P_WASH  = 3'd2,
        P_DRAIN = 3'd3,
        P_SPIN  = 3'd4
    } phase_t;

    // State encoding of the downstream washing-machine control FSM.
    typedef enum logic [2:0] {
        checkdoor    = 3'd0,
        fillwater    = 3'd1,
        adddetergent = 3'd2,
        cycle        = 3'd3,
        drainwater   = 3'd4,
        spinning     = 3'd5
    } wash_state_t;

    // Default sizing and timing constants, in clock cycles.
    localparam int DEF_CNT_W           = 16;
    localparam int DEF_CYCLE_TICKS     = 1000;
    localparam int DEF_SPIN_TICKS      = 500;
    localparam int DEF_DEB_CYCLES      = 4;
    localparam int DEF_FILL_MAX_TICKS  = 4000;
    localparam int DEF_DRAIN_MAX_TICKS = 3000;

endpackage

// File: rtl/wash_phase_timer_if.sv
// Signal bundle between the washing-machine control FSM (master) and the
// phase timer / sensor front end (slave).
interface wash_phase_timer_if #(
    parameter int CNT_W = 16
) ();

    // Actuator commands and raw sensors, driven from the FSM side.
    logic             doorlock_check;
    logic             motoron_check;
    logic             fillvalue_check;
    logic             drainvalue_check;
    logic             level_full_raw;
    logic             level_empty_raw;

    // Handshakes, timeouts and faults returned by the timer.
    logic             filledmachine;
    logic             waterdrained;
    logic             machinecycle_timeout;
    logic             spin_timeout_check;
    logic             fill_fault;
    logic             drain_fault;
    logic             valve_conflict;
    logic [CNT_W-1:0] elapsed;

    modport master (
        output doorlock_check, motoron_check, fillvalue_check, drainvalue_check,
        output level_full_raw, level_empty_raw,
        input  filledmachine, waterdrained, machinecycle_timeout, spin_timeout_check,
        input  fill_fault, drain_fault, valve_conflict, elapsed
    );

    modport slave (
        input  doorlock_check, motoron_check, fillvalue_check, drainvalue_check,
        input  level_full_raw, level_empty_raw,
        output filledmachine, waterdrained, machinecycle_timeout, spin_timeout_check,
        output fill_fault, drain_fault, valve_conflict, elapsed
    );

endinterface

// File: rtl/wash_phase_timer_level_debounce.sv
// Level-sensor debouncer: the output follows the raw input only after the raw
// input has disagreed with it for DEB_CYCLES consecutive clock edges.
module level_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level_out
);

    localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] shadow_cnt;

    // Count disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_cnt <= '0;
            level_out  <= 1'b0;
        end else if (raw_in == level_out) begin
            shadow_cnt <= '0;
        end else if (shadow_cnt == LAST) begin
            level_out  <= raw_in;
            shadow_cnt <= '0;
        end else begin
            shadow_cnt <= shadow_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer and sensor front end for the washing-machine control FSM.
// Decodes the current phase from actuator commands, times each phase with a
// saturating counter, debounces the level sensors and raises sticky faults.
module wash_phase_timer
    import wash_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int CYCLE_TICKS     = DEF_CYCLE_TICKS,
    parameter int SPIN_TICKS      = DEF_SPIN_TICKS,
    parameter int DEB_CYCLES      = DEF_DEB_CYCLES,
    parameter int FILL_MAX_TICKS  = DEF_FILL_MAX_TICKS,
    parameter int DRAIN_MAX_TICKS = DEF_DRAIN_MAX_TICKS
) (
    input  logic            clk,
    input  logic            reset,
    wash_phase_timer_if.slave bus
);

    // Every limit must be representable in the counter or its event is lost.
    if (longint'(CYCLE_TICKS)     >= (longint'(1) << CNT_W) ||
        longint'(SPIN_TICKS)      >= (longint'(1) << CNT_W) ||
        longint'(FILL_MAX_TICKS)  >= (longint'(1) << CNT_W) ||
        longint'(DRAIN_MAX_TICKS) >= (longint'(1) << CNT_W)) begin : g_bad_sizing
        $error("wash_phase_timer: tick limit does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CYCLE_LIM = CNT_W'(CYCLE_TICKS);
    localparam logic [CNT_W-1:0] SPIN_LIM  = CNT_W'(SPIN_TICKS);
    localparam logic [CNT_W-1:0] FILL_LIM  = CNT_W'(FILL_MAX_TICKS);
    localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(DRAIN_MAX_TICKS);

    phase_t           phase_d, phase_q;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             conflict_now;
    logic             filled, drained;
    logic             cycle_to_q, spin_to_q;
    logic             fill_fault_q, drain_fault_q, conflict_q;

    level_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_full_deb (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (bus.level_full_raw),
        .level_out (filled)
    );

    level_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_empty_deb (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (bus.level_empty_raw),
        .level_out (drained)
    );

    // Priority phase decode and next counter value.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        phase_d      = P_IDLE;
        cnt_next     = '0;
        conflict_now = bus.fillvalue_check & bus.drainvalue_check;

        if (!bus.doorlock_check)       phase_d = P_IDLE;
        else if (conflict_now)         phase_d = P_IDLE;
        else if (bus.fillvalue_check)  phase_d = P_FILL;
        else if (bus.motoron_check)    phase_d = P_WASH;
        else if (bus.drainvalue_check) phase_d = drained ? P_SPIN : P_DRAIN;

        if (phase_d == P_IDLE)       cnt_next = '0;
        else if (phase_d != phase_q) cnt_next = CNT_W'(1);
        else if (cnt_q == '1)        cnt_next = cnt_q;
        else                         cnt_next = cnt_q + 1'b1;
    end

    // Phase/counter registers, timeouts and sticky faults.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            phase_q       <= P_IDLE;
            cnt_q         <= '0;
            cycle_to_q    <= 1'b0;
            spin_to_q     <= 1'b0;
            fill_fault_q  <= 1'b0;
            drain_fault_q <= 1'b0;
            conflict_q    <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            cnt_q         <= cnt_next;
            cycle_to_q    <= (phase_d == P_WASH) && (phase_q == P_WASH) && (cnt_q >= CYCLE_LIM);
            spin_to_q     <= (phase_d == P_SPIN) && (phase_q == P_SPIN) && (cnt_q >= SPIN_LIM);
            fill_fault_q  <= fill_fault_q  | ((phase_d == P_FILL) && (cnt_next >= FILL_LIM) && !filled);
            drain_fault_q <= drain_fault_q | ((phase_d == P_DRAIN) && (cnt_next >= DRAIN_LIM));
            conflict_q    <= conflict_q | conflict_now;
        end
    end

    assign bus.filledmachine        = filled;
    assign bus.waterdrained         = drained;
    assign bus.machinecycle_timeout = cycle_to_q;
    assign bus.spin_timeout_check   = spin_to_q;
    assign bus.fill_fault           = fill_fault_q;
    assign bus.drain_fault          = drain_fault_q;
    assign bus.valve_conflict       = conflict_q;
    assign bus.elapsed              = cnt_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Self-checking bench for wash_phase_timer: a cycle model pushes expected
// outputs into a scoreboard queue as each input vector is driven, and the
// entry is popped and compared once the DUT has taken the clock edge.
module tb_wash_phase_timer;
    import wash_pkg::*;

    localparam int CNT_W       = 8;
    localparam int CYCLE_TICKS = 8;
    localparam int SPIN_TICKS  = 5;
    localparam int DEB_CYCLES  = 3;
    localparam int FILL_MAX    = 20;
    localparam int DRAIN_MAX   = 15;
    localparam int SAT         = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wash_phase_timer_if #(.CNT_W(CNT_W)) bus ();

    wash_phase_timer #(
        .CNT_W           (CNT_W),
        .CYCLE_TICKS     (CYCLE_TICKS),
        .SPIN_TICKS      (SPIN_TICKS),
        .DEB_CYCLES      (DEB_CYCLES),
        .FILL_MAX_TICKS  (FILL_MAX),
        .DRAIN_MAX_TICKS (DRAIN_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic             fm;
        logic             wd;
        logic             mct;
        logic             sto;
        logic             ff;
        logic             df;
        logic             vc;
        logic [CNT_W-1:0] el;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state, written in terms of run lengths of each phase.
    phase_t m_ph;
    int     m_len;
    int     m_full_run, m_empty_run;
    exp_t   m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic phase_t decode(input logic lock, mot, fill, drain, wd);
        if (!lock)             return P_IDLE;
        if (fill && drain)     return P_IDLE;
        if (fill)              return P_FILL;
        if (mot)               return P_WASH;
        if (drain && !wd)      return P_DRAIN;
        if (drain && wd)       return P_SPIN;
        return P_IDLE;
    endfunction

    // Advance the model by one edge with the currently driven inputs.
    task automatic model_step(input logic rst);
        phase_t pd;
        if (rst) begin
            m           = '0;
            m_ph        = P_IDLE;
            m_len       = 0;
            m_full_run  = 0;
            m_empty_run = 0;
            return;
        end
        pd = decode(bus.doorlock_check, bus.motoron_check, bus.fillvalue_check,
                    bus.drainvalue_check, m.wd);
        if (pd == P_IDLE)    m_len = 0;
        else if (pd != m_ph) m_len = 1;
        else                 m_len = m_len + 1;
        m.el  = (m_len > SAT) ? CNT_W'(SAT) : CNT_W'(m_len);
        m.mct = (pd == P_WASH) && (m_len >= CYCLE_TICKS + 1);
        m.sto = (pd == P_SPIN) && (m_len >= SPIN_TICKS + 1);
        if (pd == P_FILL && m_len >= FILL_MAX && !m.fm) m.ff = 1'b1;
        if (pd == P_DRAIN && m_len >= DRAIN_MAX)        m.df = 1'b1;
        if (bus.fillvalue_check && bus.drainvalue_check) m.vc = 1'b1;
        m_ph = pd;
        // Debounce: count consecutive disagreeing samples.
        if (bus.level_full_raw != m.fm) m_full_run++; else m_full_run = 0;
        if (m_full_run == DEB_CYCLES) begin m.fm = bus.level_full_raw; m_full_run = 0; end
        if (bus.level_empty_raw != m.wd) m_empty_run++; else m_empty_run = 0;
        if (m_empty_run == DEB_CYCLES) begin m.wd = bus.level_empty_raw; m_empty_run = 0; end
    endtask

    // Drive one vector, push its expectation, take the edge, pop and compare.
    task automatic cyc(input logic rst, lock, mot, fill, drain, full, empty);
        exp_t e;
        reset                = rst;
        bus.doorlock_check   = lock;
        bus.motoron_check    = mot;
        bus.fillvalue_check  = fill;
        bus.drainvalue_check = drain;
        bus.level_full_raw   = full;
        bus.level_empty_raw  = empty;
        model_step(rst);
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb_q.pop_front();
        check("filledmachine",        32'(bus.filledmachine),        32'(e.fm));
        check("waterdrained",         32'(bus.waterdrained),         32'(e.wd));
        check("machinecycle_timeout", 32'(bus.machinecycle_timeout), 32'(e.mct));
        check("spin_timeout_check",   32'(bus.spin_timeout_check),   32'(e.sto));
        check("fill_fault",           32'(bus.fill_fault),           32'(e.ff));
        check("drain_fault",          32'(bus.drain_fault),          32'(e.df));
        check("valve_conflict",       32'(bus.valve_conflict),       32'(e.vc));
        check("elapsed",              32'(bus.elapsed),              32'(e.el));
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.doorlock_check = 0; bus.motoron_check = 0; bus.fillvalue_check = 0;
        bus.drainvalue_check = 0; bus.level_full_raw = 0; bus.level_empty_raw = 0;
        m = '0; m_ph = P_IDLE; m_len = 0; m_full_run = 0; m_empty_run = 0;

        // Reset with toggling inputs, then release with idle inputs.
        cyc(1, 1, 1, 0, 1, 1, 1);
        cyc(1, 1, 0, 1, 1, 0, 1);
        check("rst_elapsed", 32'(bus.elapsed), 32'd0);
        check("rst_vc", 32'(bus.valve_conflict), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_elapsed", 32'(bus.elapsed), 32'd0);

        // Wash: timeout rises on edge 8 after motor start, clears when motor drops.
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 1, 0, 0, 0, 0);
            if (k == 7) check("wash_edge7_low", 32'(bus.machinecycle_timeout), 32'd0);
            if (k == 8) check("wash_edge8_high", 32'(bus.machinecycle_timeout), 32'd1);
        end
        check("wash_elapsed10", 32'(bus.elapsed), 32'd10);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("wash_drop_to", 32'(bus.machinecycle_timeout), 32'd0);
        check("wash_drop_el", 32'(bus.elapsed), 32'd0);

        // Debounce: 1,1,0 glitch then 1,1,1 run.
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check("deb_glitch", 32'(bus.filledmachine), 32'd0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        check("deb_two", 32'(bus.filledmachine), 32'd0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        check("deb_three", 32'(bus.filledmachine), 32'd1);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 0, 0);
        check("deb_fall", 32'(bus.filledmachine), 32'd0);

        // Drain then spin once the empty sensor settles.
        for (int k = 0; k < 12; k++) begin
            cyc(0, 1, 0, 0, 1, 0, 1);
            if (k == 2) check("drain_wd", 32'(bus.waterdrained), 32'd1);
            if (k == 3) check("spin_restart", 32'(bus.elapsed), 32'd1);
            if (k == 7) check("spin_edge7_low", 32'(bus.spin_timeout_check), 32'd0);
            if (k == 8) check("spin_edge8_high", 32'(bus.spin_timeout_check), 32'd1);
        end
        cyc(0, 1, 0, 0, 0, 0, 1);
        check("spin_clear", 32'(bus.spin_timeout_check), 32'd0);

        // Fill watchdog: fault on the 20th fill edge, sticky afterwards.
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, 0, 1, 0, 0, 1);
            if (k == 18) check("fill_wd_19", 32'(bus.fill_fault), 32'd0);
        end
        check("fill_wd_20", 32'(bus.fill_fault), 32'd1);
        idle_cyc(2);
        check("fill_sticky", 32'(bus.fill_fault), 32'd1);

        // Valve conflict for a single cycle.
        cyc(0, 1, 0, 1, 1, 0, 1);
        check("conflict_set", 32'(bus.valve_conflict), 32'd1);
        check("conflict_idle", 32'(bus.elapsed), 32'd0);
        idle_cyc(3);
        check("conflict_sticky", 32'(bus.valve_conflict), 32'd1);

        // Drain watchdog: empty sensor drops, drain runs long.
        for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 1, 0, 0);
        check("drain_wd", 32'(bus.drain_fault), 32'd1);
        idle_cyc(1);

        // Door abort at wash count 5, then relock and restart from zero.
        for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("abort_el", 32'(bus.elapsed), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 1, 0, 0, 0, 0);
            if (k == 7) check("relock_edge7_low", 32'(bus.machinecycle_timeout), 32'd0);
            if (k == 8) check("relock_edge8_high", 32'(bus.machinecycle_timeout), 32'd1);
        end

        // Mid-operation reset wins and clears the sticky faults.
        cyc(1, 1, 1, 1, 1, 1, 1);
        check("midrst_ff", 32'(bus.fill_fault), 32'd0);
        check("midrst_mct", 32'(bus.machinecycle_timeout), 32'd0);

        // Counter saturation: elapsed holds at all-ones, timeout stays high.
        for (int k = 0; k < 270; k++) cyc(0, 1, 1, 0, 0, 0, 0);
        check("sat_elapsed", 32'(bus.elapsed), 32'(SAT));
        check("sat_timeout", 32'(bus.machinecycle_timeout), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
